pll_lock_sequencer: RTL
=======================

# pll_lock_sequencer

Supervisor and reset sequencer for the ECP5 system PLL (25 MHz in, 50 MHz pixel/Sobel clock out). Runs on the free-running 25 MHz board clock, drives the PLL reset, qualifies the PLL lock signal, and releases two staged resets: first the camera/SCCB configuration domain, then the Sobel pipeline. It retries the PLL on lock timeout and latches a fault after a bounded number of retries. It also tears down both resets on lock loss.

## Interface
- RST_PULSE, 16: clocks `pll_rst` is held high per PLL reset attempt (≥2).
- LOCK_TIMEOUT, 65536: clocks allowed in WAIT_LOCK before a retry (≥4).
- STABLE_CYCLES, 1024: consecutive synchronized-lock clocks required before releasing resets (≥2).
- STAGGER_CYCLES, 256: clocks between `cam_rst_n` and `sys_rst_n` release (≥2).
- MAX_RETRY, 7: PLL reset attempts after the first before FAULT (1..7).
- Counter width: one shared counter of clog2(max of the four cycle parameters) bits.

- clk  in  1  25 MHz board clock, free-running, independent of the PLL.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL LOCK output, asynchronous to `clk`.
- pll_rst  out  1  PLL RST input, active-high.
- cam_rst_n  out  1  camera/config domain reset, active-low.
- sys_rst_n  out  1  Sobel pipeline reset, active-low.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  3  PLL reset attempts since the last RUN entry, saturating at MAX_RETRY.
- state_dbg  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, STAGGER=3, RUN=4, FAULT=5.

## Operation
- `pll_locked` passes through a 2-FF synchronizer; the result is `lock_s`. All decisions use `lock_s` only.
- All outputs are registered.
- Reset values while `rst_n`=0: state RESET_PLL, counter 0, retry_cnt 0, `pll_rst`=1, `cam_rst_n`=0, `sys_rst_n`=0, `ready`=0, `fault`=0, synchronizer 0.
- RESET_PLL: `pll_rst`=1 and both resets asserted. The counter counts 0..RST_PULSE-1. At count RST_PULSE-1: `pll_rst`←0, counter←0, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1: counter←0, go to STABILIZE.
  - Else, at count LOCK_TIMEOUT-1 with retry_cnt<MAX_RETRY: retry_cnt++, go to RESET_PLL.
  - Else, at count LOCK_TIMEOUT-1 with retry_cnt=MAX_RETRY: go to FAULT.
  - Otherwise the counter increments.
- STABILIZE:
  - If `lock_s`=0: counter←0, go to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
  - At count STABLE_CYCLES-1 with `lock_s`=1: `cam_rst_n`←1, counter←0, go to STAGGER.
- STAGGER: at count STAGGER_CYCLES-1: `sys_rst_n`←1, `ready`←1, retry_cnt←0, go to RUN.
- RUN: hold outputs until `lock_s`=0.
- Lock loss in STAGGER or RUN (`lock_s`=0):
  - On that same edge: `cam_rst_n`←0, `sys_rst_n`←0, `ready`←0, counter←0, go to WAIT_LOCK.
  - The PLL is not reset.
  - This has priority over the count-complete transitions in STAGGER.
- FAULT: `pll_rst`=1, both resets asserted, `fault`=1. The block stays in FAULT until `rst_n` is asserted. `pll_locked` is ignored.
- Simultaneous events in WAIT_LOCK: `lock_s`=1 on the timeout cycle takes priority and the block goes to STABILIZE.
- Unused state encodings recover to RESET_PLL.

## Timing
- Synchronizer latency is 2 clocks. Let edge k be the first edge sampling `pll_locked`=1, with the block in WAIT_LOCK.
  - STABILIZE is entered at edge k+2.
  - `cam_rst_n` rises at edge k+2+STABLE_CYCLES.
  - `sys_rst_n` and `ready` rise STAGGER_CYCLES edges after `cam_rst_n`.
- `pll_rst` is high for exactly RST_PULSE clocks per attempt. The first attempt starts at the first edge after `rst_n` deasserts.
- Lock loss: both resets fall at edge j+2, where edge j is the first edge sampling `pll_locked`=0. The falls are asynchronous to the PLL domain; downstream domains re-synchronize the deassertion.
- Assertion of `rst_n` mid-operation takes effect immediately and asynchronously: all outputs go to their reset values without waiting for a clock edge.

## Test plan
Parameters for all scenarios: RST_PULSE=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGGER_CYCLES=4, MAX_RETRY=2.
- Bring-up: release `rst_n`, raise `pll_locked` at edge k=10 -> `pll_rst` high on edges 0–3, then low; `cam_rst_n` rises at edge 20; `sys_rst_n` and `ready` rise at edge 24; retry_cnt=0.
- Lock glitch: `pll_locked` low for 3 clocks in mid-STABILIZE -> return to WAIT_LOCK; full 8-cycle qualification restarts; `cam_rst_n` stays 0 throughout the glitch.
- Lock loss in RUN: drop `pll_locked` at edge j -> `cam_rst_n`, `sys_rst_n` and `ready` all 0 at edge j+2; `pll_rst` stays 0; re-lock repeats the 8+4 release sequence.
- Timeout retry: hold `pll_locked`=0 -> `pll_rst` re-pulses after 32 WAIT_LOCK clocks; retry_cnt steps 1, then 2; then FAULT with `fault`=1 and `pll_rst`=1. A later `pll_locked`=1 has no effect.
- Recovery: lock on the second retry, then reach RUN -> retry_cnt clears to 0.
- Async reset mid-RUN: assert `rst_n` between edges -> outputs take reset values before the next edge; deassert -> the sequence restarts at RESET_PLL.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, and releases the camera
// and Sobel resets in stages; retries on lock timeout and latches a fault.
module pll_lock_sequencer #(
    parameter int RST_PULSE      = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 256,
    parameter int MAX_RETRY      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       cam_rst_n,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int MAX_AB = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [2:0]    MAXR     = 3'(MAX_RETRY);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILIZE = 3'd2;
    localparam logic [2:0] S_STAGGER   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          sync1, lock_s;

    assign state_dbg = state;

    // pll_locked comes from the PLL domain; only lock_s is used past here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_locked;
            lock_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= 3'd0;
            pll_rst   <= 1'b1;
            cam_rst_n <= 1'b0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // lock wins over a coincident timeout
                    if (lock_s) begin
                        cnt   <= '0;
                        state <= S_STABILIZE;
                    end else if (cnt == TO_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt < MAXR) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            state     <= S_RESET_PLL;
                        end else begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABILIZE: begin
                    if (!lock_s) begin
                        cnt   <= '0;
                        state <= S_WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        cam_rst_n <= 1'b1;
                        cnt       <= '0;
                        state     <= S_STAGGER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STAGGER, S_RUN: begin
                    // lock loss tears down both domains but leaves the PLL running
                    if (!lock_s) begin
                        cam_rst_n <= 1'b0;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        cnt       <= '0;
                        state     <= S_WAIT_LOCK;
                    end else if (state == S_STAGGER) begin
                        if (cnt == STG_LAST) begin
                            sys_rst_n <= 1'b1;
                            ready     <= 1'b1;
                            retry_cnt <= 3'd0;
                            cnt       <= '0;
                            state     <= S_RUN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    pll_rst   <= 1'b1;
                    cam_rst_n <= 1'b0;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state     <= S_RESET_PLL;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    cam_rst_n <= 1'b0;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
